vec_serial_tx: RTL and testbench

- Serialising transmitter that turns parallel WIDTH-bit vectors into framed serial bit streams for the serial pattern detectors.
- Accepts one vector per valid/ready handshake and sends it on a single wire as: start bit (0), data MSB-first, stop bit (1).
- Flags frames whose payload is all ones, so a bench can cross-check the detector outputs.
- Sits between the vector stimulus source and the serial detector input.

---
 rtl/vec_serial_tx_pkg.sv | 16 +
 rtl/vec_serial_tx_if.sv | 27 ++
 rtl/vec_serial_tx_bit_timer.sv | 32 +++
 rtl/vec_serial_tx.sv | 121 ++++++++++++
 tb/tb_vec_serial_tx.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/vec_serial_tx_pkg.sv
// Shared types and constants for the vector serial transmitter.
// The frame line levels and the frame-length helper live here so the top and any bench agree.
package vec_tx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Clock cycles one complete frame occupies on the serial line.
    function automatic int unsigned frame_len(input int unsigned width, input int unsigned bit_cycles);
        return (width + 2) * bit_cycles;
    endfunction

endpackage

// File: rtl/vec_serial_tx_if.sv
// Bundle of the vector handshake and the serial-side status signals of vec_serial_tx.
// The slave modport is the transmitter's view; the master modport is the source/monitor view.
interface vec_serial_tx_if #(
    parameter int WIDTH = 9,
    parameter int CNT_W = 16
) ();

    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic             tx_out;
    logic             tx_active;
    logic             frame_done;
    logic             all_ones;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output data_in, in_valid,
        input  in_ready, tx_out, tx_active, frame_done, all_ones, frame_cnt
    );

    modport slave (
        input  data_in, in_valid,
        output in_ready, tx_out, tx_active, frame_done, all_ones, frame_cnt
    );

endinterface

// File: rtl/vec_serial_tx_bit_timer.sv
// Per-bit pacing counter: counts 0..BIT_CYCLES-1 while enabled and flags the last cycle of a bit.
// Idle or a state change returns it to zero so every bit starts with a full period.
module bit_timer #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_tc      = i_en && w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vec_serial_tx.sv
// Serialising transmitter: frames each accepted vector as start bit, MSB-first payload, stop bit.
// Outputs depend only on registered state, so in_valid never reaches an output combinationally.
module vec_serial_tx
    import vec_tx_pkg::*;
#(
    parameter int WIDTH      = 9,
    parameter int BIT_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    vec_serial_tx_if.slave bus
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_all_ones;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_frame_cnt;

    logic w_tc;
    logic w_timer_en;
    logic w_state_chg;
    logic w_accept;
    logic w_last_bit;
    logic w_stop_end;
    logic w_tx;

    assign w_timer_en  = (r_state != IDLE);
    assign w_state_chg = (w_state_next != r_state);
    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_stop_end  = (r_state == STOP) && w_tc;

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_timer_en),
        .i_clr (w_state_chg),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_tx         = IDLE_LEVEL;
        case (r_state)
            IDLE: begin
                w_tx = IDLE_LEVEL;
                if (bus.in_valid) begin
                    w_state_next = START;
                    w_accept     = 1'b1;
                end
            end
            START: begin
                w_tx = START_BIT;
                if (w_tc) w_state_next = DATA;
            end
            DATA: begin
                w_tx = r_shift[WIDTH-1];
                if (w_tc && w_last_bit) w_state_next = STOP;
            end
            STOP: begin
                w_tx = STOP_BIT;
                if (w_tc) w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_tx         = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Payload shifts out of the top bit; the bit index only advances at the end of each paced bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_all_ones <= 1'b0;
        end else if (w_accept) begin
            r_shift    <= bus.data_in;
            r_bit_cnt  <= '0;
            r_all_ones <= &bus.data_in;
        end else if ((r_state == DATA) && w_tc) begin
            r_shift    <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= w_stop_end;
            if (w_stop_end) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.tx_active  = (r_state != IDLE);
    assign bus.tx_out     = w_tx;
    assign bus.frame_done = r_frame_done;
    assign bus.all_ones   = r_all_ones;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_vec_serial_tx.sv
// Directed bench for vec_serial_tx: one instance paced at one cycle per bit with a 4-bit frame
// counter, and one paced at three cycles per bit; expected serial streams are written out by hand.
module tb_vec_serial_tx;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vec_serial_tx_if #(.WIDTH(9), .CNT_W(4))  a_if ();
    vec_serial_tx_if #(.WIDTH(9), .CNT_W(16)) b_if ();

    vec_serial_tx #(.WIDTH(9), .BIT_CYCLES(1), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    vec_serial_tx #(.WIDTH(9), .BIT_CYCLES(3), .CNT_W(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge of the cycle in which the handshake should happen.
    // Returns at the falling edge of the frame_done cycle.
    task automatic frame_a(input logic [8:0] d, input logic [10:0] ser, input logic ones,
                           input logic [3:0] cnt, input logic keep_valid, input logic [8:0] d_next);
        a_if.data_in  = d;
        a_if.in_valid = 1'b1;
        chk("a_ready_pre", a_if.in_ready, 1);
        @(posedge clk);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a_if.in_valid = keep_valid;
                a_if.data_in  = d_next;
            end
            chk("a_tx_bit", a_if.tx_out, ser[10-i]);
            chk("a_active", a_if.tx_active, 1);
            chk("a_ready_busy", a_if.in_ready, 0);
            chk("a_done_busy", a_if.frame_done, 0);
        end
        @(negedge clk);
        chk("a_done", a_if.frame_done, 1);
        chk("a_cnt", a_if.frame_cnt, cnt);
        chk("a_all_ones", a_if.all_ones, ones);
        chk("a_tx_idle", a_if.tx_out, 1);
        chk("a_ready_done", a_if.in_ready, 1);
        $display("frame a data=%03h all_ones=%0d frame_cnt=%0d", d, a_if.all_ones, a_if.frame_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] d;

        rst_n         = 1'b0;
        a_if.data_in  = '0;
        a_if.in_valid = 1'b0;
        b_if.data_in  = '0;
        b_if.in_valid = 1'b0;
        #1;
        chk("rst_tx", a_if.tx_out, 1);
        chk("rst_ready", a_if.in_ready, 1);
        chk("rst_active", a_if.tx_active, 0);
        chk("rst_done", a_if.frame_done, 0);
        chk("rst_ones", a_if.all_ones, 0);
        chk("rst_cnt", a_if.frame_cnt, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle with no valid for 20 cycles.
        repeat (20) begin
            @(negedge clk);
            chk("idle_tx", a_if.tx_out, 1);
            chk("idle_ready", a_if.in_ready, 1);
            chk("idle_active", a_if.tx_active, 0);
            chk("idle_cnt", a_if.frame_cnt, 0);
            chk("idle_tx_b", b_if.tx_out, 1);
        end

        // All-ones payload, then a back-to-back pair with valid held through the first frame.
        frame_a(9'h1FF, 11'b0_111111111_1, 1'b1, 4'd1, 1'b0, 9'h000);
        @(negedge clk);
        chk("a_done_clear", a_if.frame_done, 0);
        frame_a(9'h155, 11'b0_101010101_1, 1'b0, 4'd2, 1'b1, 9'h0AA);
        frame_a(9'h0AA, 11'b0_010101010_1, 1'b0, 4'd3, 1'b0, 9'h1FF);
        @(negedge clk);
        chk("a_done_clear2", a_if.frame_done, 0);

        // Reset during the fifth cycle of a frame.
        a_if.data_in  = 9'h1FF;
        a_if.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_active_pre", a_if.tx_active, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", a_if.tx_out, 1);
        chk("mid_rst_active", a_if.tx_active, 0);
        chk("mid_rst_ready", a_if.in_ready, 1);
        chk("mid_rst_cnt", a_if.frame_cnt, 0);
        chk("mid_rst_ones", a_if.all_ones, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) begin
            @(negedge clk);
            chk("post_rst_done", a_if.frame_done, 0);
            chk("post_rst_tx", a_if.tx_out, 1);
            chk("post_rst_cnt", a_if.frame_cnt, 0);
        end

        // 17 frames through the 4-bit counter: 15 -> 0 -> 1.
        for (int n = 1; n <= 17; n++) begin
            d = (n == 16) ? 9'h1FF : 9'(n * 91);
            frame_a(d, {1'b0, d, 1'b1}, (d == 9'h1FF), 4'(n % 16), 1'b0, ~d);
            @(negedge clk);
            chk("a_gap_done", a_if.frame_done, 0);
        end

        // Three cycles per bit: 3 low, 3 high, 24 low, 3 high.
        b_if.data_in  = 9'h100;
        b_if.in_valid = 1'b1;
        chk("b_ready_pre", b_if.in_ready, 1);
        @(posedge clk);
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (i == 0) begin
                b_if.in_valid = 1'b0;
                b_if.data_in  = 9'h0FF;
            end
            chk("b_tx_bit", b_if.tx_out, (i < 3) ? 0 : (i < 6) ? 1 : (i < 30) ? 0 : 1);
            chk("b_active", b_if.tx_active, 1);
            chk("b_done_busy", b_if.frame_done, 0);
        end
        @(negedge clk);
        chk("b_done", b_if.frame_done, 1);
        chk("b_cnt", b_if.frame_cnt, 1);
        chk("b_all_ones", b_if.all_ones, 0);
        chk("b_active_end", b_if.tx_active, 0);
        $display("frame b data=100 all_ones=%0d frame_cnt=%0d", b_if.all_ones, b_if.frame_cnt);
        @(negedge clk);
        chk("b_done_clear", b_if.frame_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
